// File: rtl/serial_in.sv
// Slave-side serial receiver: host streams a length header then DW-bit words on sSCLK/sMOSI
// framed by sSS_n, and each word becomes a single-cycle SRAM write at sequential addresses.
module serial_in #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sSCLK,
    input  logic          sMOSI,
    input  logic          sSS_n,
    input  logic          enable,
    output logic          busy,
    output logic          wen,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] count
);

    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic            r_mosi_s1, r_mosi_s2;
    logic            r_ss_s1, r_ss_s2, r_ss_d;
    logic [DW-1:0]   r_shift;
    logic [BW-1:0]   r_bitcnt;
    logic [AW-1:0]   r_len;
    logic [AW-1:0]   r_ptr;

    logic            w_sclk_rise;
    logic            w_ss_fall;
    logic            w_ss_rise;
    logic            w_last_bit;
    logic            w_word_done;
    logic [DW-1:0]   w_word;
    logic [AW-1:0]   w_count_next;
    logic            w_final;
    logic            w_abort;

    assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_d;
    assign w_ss_fall    = ~r_ss_s2 & r_ss_d;
    assign w_ss_rise    = r_ss_s2 & ~r_ss_d;
    assign w_last_bit   = (r_bitcnt == BW'(DW - 1));
    assign w_word_done  = w_sclk_rise & w_last_bit;
    assign w_word       = {r_shift[DW-2:0], r_mosi_s2};
    assign w_count_next = count + AW'(1);
    // A length of 0 compares equal after 2^AW writes because the counter wraps.
    assign w_final      = (w_count_next == r_len);
    assign w_abort      = w_ss_rise | ~enable;

    // Two-flop synchronisers plus edge-detect delay stages for the external pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_ss_s1   <= 1'b1;
            r_ss_s2   <= 1'b1;
            r_ss_d    <= 1'b1;
        end else begin
            r_sclk_s1 <= sSCLK;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_mosi_s1 <= sMOSI;
            r_mosi_s2 <= r_mosi_s1;
            r_ss_s1   <= sSS_n;
            r_ss_s2   <= r_ss_s1;
            r_ss_d    <= r_ss_s2;
        end
    end

    // Frame FSM: word assembly, SRAM write strobes, completion and abort handling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_len    <= '0;
            r_ptr    <= '0;
            busy     <= 1'b0;
            wen      <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
        end else begin
            wen  <= 1'b0;
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (w_ss_fall && enable) begin
                        r_state  <= S_HEADER;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        count    <= '0;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                    end
                end
                S_HEADER, S_DATA: begin
                    if (w_sclk_rise) begin
                        r_shift  <= w_word;
                        r_bitcnt <= w_last_bit ? '0 : r_bitcnt + BW'(1);
                    end
                    if (w_word_done) begin
                        if (r_state == S_HEADER) begin
                            r_len   <= AW'(w_word);
                            r_ptr   <= '0;
                            addr    <= '0;
                            r_state <= S_DATA;
                        end else begin
                            wen   <= 1'b1;
                            wdata <= w_word;
                            addr  <= r_ptr;
                            r_ptr <= r_ptr + AW'(1);
                            count <= w_count_next;
                            if (w_final) begin
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                r_state <= S_DONE;
                            end
                        end
                    end
                    // A word completed alongside the abort is already written above.
                    if (w_abort && !(w_word_done && (r_state == S_DATA) && w_final)) begin
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= S_IDLE;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    if (r_ss_s2) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
